// File: rtl/gpio_ctrl_bank_if.sv
// Simple valid/ready memory bus between a CPU-side master and the GPIO register bank.
// The slave acknowledges each accepted request with a single-cycle mem_ready pulse.
interface gpio_ctrl_bank_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/gpio_ctrl_bank.sv
// GPIO register bank: writable output channels plus synchronized, debounced buttons
// with sticky rising-edge flags and a masked level interrupt.
module gpio_ctrl_bank #(
    parameter int unsigned N_CH    = 3,
    parameter int unsigned CH_W    = 4,
    parameter int unsigned N_BTN   = 2,
    parameter int unsigned DEB_CNT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gpio_ctrl_bank_if.slave        bus,
    input  logic [N_BTN-1:0]       btns,
    output logic [N_CH*CH_W-1:0]   ch_out,
    output logic                   irq
);

    localparam int unsigned CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [5:0] IDX_BTN   = 6'd8;
    localparam logic [5:0] IDX_EDGE  = 6'd9;
    localparam logic [5:0] IDX_IRQEN = 6'd10;
    localparam logic [5:0] IDX_PARAM = 6'd11;

    logic              ready_q;
    logic [31:0]       rdata_q, rdata_d, rd_val;
    logic [CH_W-1:0]   ch_q [N_CH];
    logic [CH_W-1:0]   ch_d [N_CH];
    logic [N_BTN-1:0]  sync1_q, sync2_q;
    logic [N_BTN-1:0]  btn_q, btn_d;
    logic [N_BTN-1:0]  edge_q, edge_d, edge_clr, rise;
    logic [N_BTN-1:0]  irq_en_q, irq_en_d;
    logic [CNT_W-1:0]  cnt_q [N_BTN];
    logic [CNT_W-1:0]  cnt_d [N_BTN];

    logic        accept, is_write, wr_acc;
    logic [5:0]  idx;
    logic [31:0] bmask;

    // Address bits outside [7:2] are intentionally ignored.
    logic unused_bus;
    assign unused_bus = ^{bus.mem_addr[31:8], bus.mem_addr[1:0], bus.mem_wdata};

    assign accept   = bus.mem_valid & ~ready_q;
    assign is_write = |bus.mem_wstrb;
    assign wr_acc   = accept & is_write;
    assign idx      = bus.mem_addr[7:2];
    assign bmask    = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                       {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_d[i] = ch_q[i];
            if (wr_acc && idx == 6'(i)) begin
                ch_d[i] = (ch_q[i] & ~bmask[CH_W-1:0]) | (bus.mem_wdata[CH_W-1:0] & bmask[CH_W-1:0]);
            end
        end
        irq_en_d = irq_en_q;
        if (wr_acc && idx == IDX_IRQEN) begin
            irq_en_d = (irq_en_q & ~bmask[N_BTN-1:0]) |
                       (bus.mem_wdata[N_BTN-1:0] & bmask[N_BTN-1:0]);
        end
        edge_clr = '0;
        if (wr_acc && idx == IDX_EDGE) begin
            edge_clr = bus.mem_wdata[N_BTN-1:0] & bmask[N_BTN-1:0];
        end
    end

    // Debounce: count cycles the synchronized level disagrees with the accepted state.
    always_comb begin
        btn_d = btn_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != btn_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    btn_d[i] = ~btn_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        rise   = btn_d & ~btn_q;
        // A new edge beats a simultaneous write-1-to-clear.
        edge_d = (edge_q & ~edge_clr) | rise;
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == 6'(i)) rd_val = 32'(ch_q[i]);
        end
        case (idx)
            IDX_BTN:   rd_val = 32'(btn_q);
            IDX_EDGE:  rd_val = 32'(edge_q);
            IDX_IRQEN: rd_val = 32'(irq_en_q);
            IDX_PARAM: rd_val = {8'd0, 8'(N_CH), 8'(CH_W), 8'(N_BTN)};
            default:   ;
        endcase
        rdata_d = (accept && !is_write) ? rd_val : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            btn_q    <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            for (int i = 0; i < N_CH; i++) ch_q[i] <= '0;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
        end else begin
            ready_q  <= accept;
            rdata_q  <= rdata_d;
            sync1_q  <= btns;
            sync2_q  <= sync1_q;
            btn_q    <= btn_d;
            edge_q   <= edge_d;
            irq_en_q <= irq_en_d;
            for (int i = 0; i < N_CH; i++) ch_q[i] <= ch_d[i];
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign irq           = |(edge_q & irq_en_q);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign ch_out[g*CH_W +: CH_W] = ch_q[g];
    end

endmodule

// File: tb/tb_gpio_ctrl_bank.sv
// Directed bench for gpio_ctrl_bank with default parameters; expected values are
// hand-computed constants.
module tb_gpio_ctrl_bank;

    localparam logic [31:0] PARAM_VAL = 32'h0003_0402;

    logic        clk;
    logic        rst_n;
    logic [1:0]  btns;
    logic [11:0] ch_out;
    logic        irq;

    int n_vec;
    int n_err;

    gpio_ctrl_bank_if bif();

    gpio_ctrl_bank dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bif),
        .btns   (btns),
        .ch_out (ch_out),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Called just after a clock edge with mem_ready low; returns just after the edge
    // following the acknowledge, so back-to-back calls see a fresh accept.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata, output int lat);
        bif.mem_valid = 1'b1;
        bif.mem_addr  = addr;
        bif.mem_wdata = wdata;
        bif.mem_wstrb = wstrb;
        lat = 0;
        while (lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (bif.mem_ready) break;
        end
        rdata = bif.mem_rdata;
        bif.mem_valid = 1'b0;
        bif.mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb);
        logic [31:0] rd;
        int lat;
        xfer(addr, wdata, wstrb, rd, lat);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_rdata0"}, rd, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        xfer(addr, 32'd0, 4'h0, rd, lat);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        btns  = 2'b00;
        bif.mem_valid = 1'b0;
        bif.mem_addr  = '0;
        bif.mem_wdata = '0;
        bif.mem_wstrb = '0;

        wait_edges(2);
        check("rst_ready", {31'd0, bif.mem_ready}, 32'd0);
        check("rst_rdata", bif.mem_rdata, 32'd0);
        check("rst_ch_out", {20'd0, ch_out}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(1);

        // Channel writes with byte strobes
        wr("wr_ch1", 32'h04, 32'h0000_000A, 4'b0001);
        check("ch_out_ch1", {20'd0, ch_out}, 32'h0A0);
        rd_chk("rd_ch1", 32'h04, 32'h0000_000A);
        wr("wr_ch0_unstrobed", 32'h00, 32'h0000_000F, 4'b0010);
        rd_chk("rd_ch0", 32'h00, 32'd0);
        wr("wr_ch2", 32'h08, 32'h1234_5678, 4'b0001);
        check("ch_out_ch2", {20'd0, ch_out}, 32'h8A0);
        rd_chk("rd_ch2", 32'h08, 32'd8);

        // Fixed and unmapped addresses
        rd_chk("rd_param", 32'h2C, PARAM_VAL);
        rd_chk("rd_unmapped", 32'h3C, 32'd0);
        wr("wr_unmapped", 32'h3C, 32'hFFFF_FFFF, 4'hF);
        rd_chk("rd_unmapped2", 32'h3C, 32'd0);
        wr("wr_btn_ro", 32'h20, 32'hFFFF_FFFF, 4'hF);
        rd_chk("rd_btn_ro", 32'h20, 32'd0);
        wr("wr_irqen", 32'h28, 32'h0000_000F, 4'hF);
        rd_chk("rd_irqen", 32'h28, 32'd3);

        // btns[0] stable high: BTN_STATE/EDGE set after exactly 6 edges
        btns[0] = 1'b1;
        wait_edges(5);
        check("irq_before_deb", {31'd0, irq}, 32'd0);
        wait_edges(1);
        check("irq_after_deb", {31'd0, irq}, 32'd1);
        rd_chk("rd_btn0", 32'h20, 32'd1);
        rd_chk("rd_edge0", 32'h24, 32'd1);
        wr("wr_irqen0", 32'h28, 32'd0, 4'hF);
        check("irq_masked", {31'd0, irq}, 32'd0);
        wr("wr_irqen1", 32'h28, 32'd1, 4'hF);
        check("irq_enabled", {31'd0, irq}, 32'd1);

        // 3-cycle glitch on btns[1] must be rejected
        btns[1] = 1'b1;
        wait_edges(3);
        btns[1] = 1'b0;
        wait_edges(8);
        rd_chk("rd_btn_glitch", 32'h20, 32'd1);
        rd_chk("rd_edge_glitch", 32'h24, 32'd1);

        // Write-1-to-clear
        wr("w1c_edge0", 32'h24, 32'd1, 4'h1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd_chk("rd_edge_clr", 32'h24, 32'd0);

        // btns[1] edge with IRQ_EN masking it
        btns[1] = 1'b1;
        wait_edges(8);
        check("irq_btn1_masked", {31'd0, irq}, 32'd0);
        rd_chk("rd_btn_both", 32'h20, 32'd3);
        rd_chk("rd_edge1", 32'h24, 32'd2);
        wr("w0_edge", 32'h24, 32'd0, 4'hF);
        rd_chk("rd_edge_w0", 32'h24, 32'd2);
        wr("w1c_edge1", 32'h24, 32'd2, 4'h1);
        rd_chk("rd_edge_clr1", 32'h24, 32'd0);

        // Falling edge does not set EDGE_STS
        btns[0] = 1'b0;
        wait_edges(8);
        rd_chk("rd_btn_fall", 32'h20, 32'd2);
        rd_chk("rd_edge_fall", 32'h24, 32'd0);

        // Clear accepted on the same edge a new rise is debounced: set wins
        btns[0] = 1'b1;
        wait_edges(5);
        wr("w1c_coincide", 32'h24, 32'd1, 4'h1);
        check("irq_set_wins", {31'd0, irq}, 32'd1);
        rd_chk("rd_edge_set_wins", 32'h24, 32'd1);

        // mem_valid held high: ready alternates, rdata only while ready
        bif.mem_valid = 1'b1;
        bif.mem_addr  = 32'h2C;
        bif.mem_wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b2b_ready%0d", i), {31'd0, bif.mem_ready}, 32'(i % 2));
            check($sformatf("b2b_rdata%0d", i), bif.mem_rdata, (i % 2) ? PARAM_VAL : 32'd0);
            wait_edges(1);
        end
        bif.mem_valid = 1'b0;
        wait_edges(1);

        // Reset during the accept cycle of a write; transfer re-accepted after release
        bif.mem_valid = 1'b1;
        bif.mem_addr  = 32'h00;
        bif.mem_wdata = 32'h5;
        bif.mem_wstrb = 4'hF;
        #3;
        rst_n = 1'b0;
        wait_edges(1);
        check("midrst_ready", {31'd0, bif.mem_ready}, 32'd0);
        check("midrst_ch_out", {20'd0, ch_out}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_rdata", bif.mem_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(1);
        check("refresh_ready", {31'd0, bif.mem_ready}, 32'd1);
        check("refresh_ch_out", {20'd0, ch_out}, 32'h005);
        bif.mem_valid = 1'b0;
        bif.mem_wstrb = 4'h0;
        wait_edges(1);
        rd_chk("rd_ch0_after_rst", 32'h00, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl_bank.md
GPIO_CTRL_BANK -- requirements
Module: gpio_ctrl_bank

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_CH, 3, number of writable output channel registers (1..8)
- CH_W, 4, width of each channel register (1..32)
- N_BTN, 2, number of button inputs (1..8)
- DEB_CNT, 4, consecutive stable cycles required to accept a button level change (2..65535)

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single system clock
- rst_n  in  1  reset; asynchronous and active-low
- mem_valid  in  1  bus request; held high by the master until mem_ready
- mem_addr  in  32  byte address; only bits [7:2] are decoded
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; all zero means read
- mem_rdata  out  32  read data, valid while mem_ready=1
- mem_ready  out  1  one-cycle transfer acknowledge
- btns  in  N_BTN  raw asynchronous button inputs
- ch_out  out  N_CH*CH_W  channel registers concatenated, channel 0 in the LSBs
- irq  out  1  level interrupt request

Function
REQ-003 Word index = mem_addr[7:2], decoded as follows:
- 0..N_CH-1: CH[i], read/write
- 8: BTN_STATE, debounced levels, read-only
- 9: EDGE_STS, sticky rising-edge flags, write-1-to-clear
- 10: IRQ_EN, read/write, N_BTN bits
- 11: PARAM, read-only, value {8'd0, N_CH[7:0], CH_W[7:0], N_BTN[7:0]}
- Any other index SHALL read 0 and ignore writes, and SHALL still be acknowledged.

REQ-004 Handshake:
- A transfer SHALL be accepted on a rising clk edge where mem_valid=1 and mem_ready=0.
- mem_ready SHALL be 1 in the following cycle only, giving a latency of exactly 1 cycle.
- mem_ready SHALL NOT be high for two consecutive cycles.

REQ-005 mem_rdata SHALL be registered at acceptance, hold its value while mem_ready=1, and be 0 in all other cycles.

REQ-006 Writes:
- A write SHALL take effect at the acceptance edge.
- Only bytes whose mem_wstrb bit is set SHALL update, and only bits below the register width are stored.
- A write whose register bits all fall in unstrobed bytes SHALL leave the register unchanged.

REQ-007 A read of a register in the same transfer as a write SHALL NOT occur, because a transfer is a write whenever mem_wstrb is nonzero; write transfers SHALL return mem_rdata=0.

REQ-008 Each btns bit SHALL pass through a 2-flop synchronizer before any other use.

REQ-009 Debounce, per button, with a counter of width clog2(DEB_CNT):
- The counter SHALL clear whenever the synchronized level equals BTN_STATE.
- Otherwise the counter SHALL increment.
- When the counter reaches DEB_CNT-1 while the levels still differ, BTN_STATE SHALL toggle and the counter SHALL clear.
- Total input-to-BTN_STATE latency SHALL therefore be 2+DEB_CNT cycles.

REQ-010 A 0->1 transition of BTN_STATE[i] SHALL set EDGE_STS[i] in the same cycle BTN_STATE updates; 1->0 transitions SHALL NOT set it.

REQ-011 Writing 1 to EDGE_STS[i] SHALL clear that bit; writing 0 SHALL have no effect. If a set and a clear coincide, the set SHALL win.

REQ-012 irq SHALL equal the OR-reduction of (EDGE_STS & IRQ_EN), driven combinationally from registers with no path from bus inputs.

REQ-013 ch_out SHALL reflect CH registers directly; a write SHALL be visible on ch_out one cycle after the acceptance edge.

REQ-014 Debounce and edge logic SHALL run independently of bus activity; bus stalls SHALL NOT lose edges.

Reset
REQ-015 While rst_n=0, the following SHALL be 0 asynchronously: all CH, BTN_STATE, EDGE_STS, IRQ_EN, synchronizer flops, debounce counters, mem_ready, mem_rdata and irq.

REQ-016 An assertion of rst_n mid-transfer SHALL abort the transfer with no register update. If mem_valid is still high after reset release, the transfer SHALL be accepted afresh.

REQ-017 Release of rst_n SHALL be synchronized externally; the block SHALL only require that clk run during release.

Verification (defaults: N_CH=3, CH_W=4, N_BTN=2, DEB_CNT=4)
REQ-018 Write 0x0000000A to 0x04 with wstrb=4'b0001 -> mem_ready high exactly 1 cycle later; ch_out[7:4]=4'hA on the next cycle; a read of 0x04 returns 0x0000000A.

REQ-019 Write 0xF to 0x00 with wstrb=4'b0010 -> CH0 stays 0. A read of 0x2C returns 0x00030402. A read of 0x3C returns 0 and is acknowledged.

REQ-020 Drive btns[0]=1 stably -> BTN_STATE[0]=1 and EDGE_STS[0]=1 after 6 cycles. A 3-cycle pulse on btns[1] -> BTN_STATE[1] and EDGE_STS[1] stay 0.

REQ-021 Set IRQ_EN=0x1 with EDGE_STS[0]=1 -> irq=1. Write 0x1 to 0x24 -> irq=0 on the next cycle. Repeat the clear on the same cycle a new edge is debounced -> EDGE_STS[0] remains 1.

REQ-022 Hold mem_valid high continuously for 6 cycles -> mem_ready pattern 0,1,0,1,0,1. Pulse rst_n low during the accept cycle of a write of 0x5 to 0x00 -> CH0=0 and mem_ready=0 during reset.
